// File: rtl/dram_ctl.sv
`timescale 1ns/1ps
// dram_ctl: dispatch-RAM controller.
//   Lookup path : lookupReq/irOp -> 1-cycle RAM read -> dramA/dramB/dramJ + dramValid pulse.
//   Write path  : ldReq/ldAddr/ldData -> one ramWrEn cycle -> ldDone pulse; ldBusy while active.
//   ldOverrun   : sticky, set when ldReq arrives while the controller is busy.
//   RAM ports   : ramRdAddr/ramRdEn/ramRdData (registered read, 1-cycle latency),
//                 ramWrAddr/ramWrData/ramWrEn.
// Option: DRAM_READBACK_EN adds a read-back verify after each write (VRD/VCMP states)
//   and drives ldErr on a mismatch; without it ldErr is tied low.
module dram_ctl (
    input  logic        clk,
    input  logic        rstN,
    input  logic        lookupReq,
    input  logic [0:8]  irOp,
    output logic        dramValid,
    output logic [3:0]  dramA,
    output logic [3:0]  dramB,
    output logic [10:0] dramJ,
    input  logic        ldReq,
    input  logic [8:0]  ldAddr,
    input  logic [23:0] ldData,
    output logic        ldBusy,
    output logic        ldDone,
    output logic        ldOverrun,
    output logic        ldErr,
    output logic [8:0]  ramRdAddr,
    output logic        ramRdEn,
    input  logic [23:0] ramRdData,
    output logic [8:0]  ramWrAddr,
    output logic [23:0] ramWrData,
    output logic        ramWrEn
);
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned FLD_W  = 4;
    localparam int unsigned J_W    = 11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        RDONE,
        WR,
        WDONE
`ifdef DRAM_READBACK_EN
        ,
        VRD,
        VCMP
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [FLD_W-1:0]    dram_a_q, dram_a_d;
    logic [FLD_W-1:0]    dram_b_q, dram_b_d;
    logic [J_W-1:0]      dram_j_q, dram_j_d;
    logic                overrun_q, overrun_d;
    logic                err_q, err_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    // Word bits [15:11] carry no dispatch field.
    logic unused_rd_bits;
    assign unused_rd_bits = ^ramRdData[15:11];

    // Next state and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        dram_a_d  = dram_a_q;
        dram_b_d  = dram_b_q;
        dram_j_d  = dram_j_q;
        overrun_d = overrun_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                // Writes win; a simultaneous lookupReq stays pending.
                if (ldReq) begin
                    state_d   = WR;
                    wr_addr_d = ldAddr;
                    wr_data_d = ldData;
                    err_d     = 1'b0;
                end else if (lookupReq) begin
                    state_d   = RD;
                    rd_addr_d = irOp;
                end
            end
            RD:    state_d = CAP;
            CAP: begin
                dram_a_d = ramRdData[23:20];
                dram_b_d = ramRdData[19:16];
                dram_j_d = ramRdData[10:0];
                state_d  = RDONE;
            end
            RDONE: state_d = IDLE;
`ifdef DRAM_READBACK_EN
            WR: begin
                state_d   = VRD;
                rd_addr_d = wr_addr_q;
            end
            VRD:   state_d = VCMP;
            VCMP: begin
                err_d   = (ramRdData != wr_data_q);
                state_d = WDONE;
            end
`else
            WR:    state_d = WDONE;
`endif
            WDONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (ldReq && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Strobes are decoded from the next state so they leave the flops cleanly.
    always_comb begin
        rd_en_d = (state_d == RD);
        busy_d  = (state_d == WR) || (state_d == WDONE);
`ifdef DRAM_READBACK_EN
        rd_en_d = rd_en_d || (state_d == VRD);
        busy_d  = busy_d || (state_d == VRD) || (state_d == VCMP);
`endif
        wr_en_d = (state_d == WR);
        valid_d = (state_d == RDONE);
        done_d  = (state_d == WDONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            dram_a_q  <= '0;
            dram_b_q  <= '0;
            dram_j_q  <= '0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            dram_a_q  <= dram_a_d;
            dram_b_q  <= dram_b_d;
            dram_j_q  <= dram_j_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign dramValid = valid_q;
    assign dramA     = dram_a_q;
    assign dramB     = dram_b_q;
    assign dramJ     = dram_j_q;
    assign ldBusy    = busy_q;
    assign ldDone    = done_q;
    assign ldOverrun = overrun_q;
    assign ramRdAddr = rd_addr_q;
    assign ramRdEn   = rd_en_q;
    assign ramWrAddr = wr_addr_q;
    assign ramWrData = wr_data_q;
    assign ramWrEn   = wr_en_q;
`ifdef DRAM_READBACK_EN
    assign ldErr     = err_q;
`else
    assign ldErr     = 1'b0;
    logic unused_err;
    assign unused_err = err_q ^ err_d;
`endif

endmodule

// File: tb/tb_dram_ctl.sv
`timescale 1ns/1ps
module tb_dram_ctl;
`ifdef DRAM_READBACK_EN
    localparam int WL = 4;
    localparam bit RB = 1'b1;
`else
    localparam int WL = 2;
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        lookupReq = 1'b0;
    logic [0:8]  irOp = '0;
    logic        dramValid;
    logic [3:0]  dramA, dramB;
    logic [10:0] dramJ;
    logic        ldReq = 1'b0;
    logic [8:0]  ldAddr = '0;
    logic [23:0] ldData = '0;
    logic        ldBusy, ldDone, ldOverrun, ldErr;
    logic [8:0]  ramRdAddr, ramWrAddr;
    logic        ramRdEn, ramWrEn;
    logic [23:0] ramRdData = '0;
    logic [23:0] ramWrData;

    always #5 clk = ~clk;

    dram_ctl dut (
        .clk(clk), .rstN(rstN), .lookupReq(lookupReq), .irOp(irOp),
        .dramValid(dramValid), .dramA(dramA), .dramB(dramB), .dramJ(dramJ),
        .ldReq(ldReq), .ldAddr(ldAddr), .ldData(ldData),
        .ldBusy(ldBusy), .ldDone(ldDone), .ldOverrun(ldOverrun), .ldErr(ldErr),
        .ramRdAddr(ramRdAddr), .ramRdEn(ramRdEn), .ramRdData(ramRdData),
        .ramWrAddr(ramWrAddr), .ramWrData(ramWrData), .ramWrEn(ramWrEn)
    );

    // RAM with a fault: an all-ones word is stored as zero.
    function automatic logic [23:0] stored(input logic [23:0] d);
        return (d == 24'hFFFFFF) ? 24'h000000 : d;
    endfunction

    logic [23:0] ram  [0:511];
    logic [23:0] mmem [0:511];

    always @(posedge clk) begin
        if (ramWrEn) ram[ramWrAddr] <= stored(ramWrData);
        if (ramRdEn) ramRdData <= ram[ramRdAddr];
    end

    // Reference model: current transaction kind and edges since acceptance.
    int          kind = 0;   // 0 none, 1 lookup, 2 write
    int          age  = 0;
    logic [23:0] lk_word = '0;
    logic        e_valid = 0, e_rden = 0, e_wren = 0, e_busy = 0, e_done = 0, e_ovr = 0, e_err = 0;
    logic [3:0]  e_a = '0, e_b = '0;
    logic [10:0] e_j = '0;
    logic [8:0]  e_raddr = '0, e_waddr = '0;
    logic [23:0] e_wdata = '0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            kind = 0; age = 0;
            e_valid = 0; e_rden = 0; e_wren = 0; e_busy = 0; e_done = 0; e_ovr = 0; e_err = 0;
            e_a = '0; e_b = '0; e_j = '0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        end else begin
            if (kind == 0) begin
                if (ldReq) begin
                    kind = 2; age = 0; e_waddr = ldAddr; e_wdata = ldData; e_err = 0;
                end else if (lookupReq) begin
                    kind = 1; age = 0; e_raddr = irOp; lk_word = mmem[irOp];
                end
            end else begin
                if (ldReq) e_ovr = 1;
                age++;
                if (kind == 2 && age == 1) mmem[e_waddr] = stored(e_wdata);
                if (kind == 2 && age == 1 && RB) e_raddr = e_waddr;
                if (kind == 2 && age == 3 && RB) e_err = (stored(e_wdata) != e_wdata);
                if (kind == 1 && age == 2) begin
                    e_a = lk_word[23:20]; e_b = lk_word[19:16]; e_j = lk_word[10:0];
                end
                if ((kind == 1 && age == 3) || (kind == 2 && age == WL)) kind = 0;
            end
            e_rden  = (kind == 1 && age == 0) || (RB && kind == 2 && age == 1);
            e_wren  = (kind == 2 && age == 0);
            e_valid = (kind == 1 && age == 2);
            e_done  = (kind == 2 && age == WL - 1);
            e_busy  = (kind == 2);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge clk) begin
        chk("dramValid", 32'(dramValid), 32'(e_valid));
        chk("dramA", 32'(dramA), 32'(e_a));
        chk("dramB", 32'(dramB), 32'(e_b));
        chk("dramJ", 32'(dramJ), 32'(e_j));
        chk("ldBusy", 32'(ldBusy), 32'(e_busy));
        chk("ldDone", 32'(ldDone), 32'(e_done));
        chk("ldOverrun", 32'(ldOverrun), 32'(e_ovr));
        chk("ldErr", 32'(ldErr), 32'(e_err));
        chk("ramRdEn", 32'(ramRdEn), 32'(e_rden));
        chk("ramRdAddr", 32'(ramRdAddr), 32'(e_raddr));
        chk("ramWrEn", 32'(ramWrEn), 32'(e_wren));
        chk("ramWrAddr", 32'(ramWrAddr), 32'(e_waddr));
        chk("ramWrData", 32'(ramWrData), 32'(e_wdata));
    end

    int n, wr_cnt, done_at, valid_at;
    logic err_at_done;

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i]  = 24'($urandom);
            mmem[i] = ram[i];
        end
        #1 rstN = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset dramValid", 32'(dramValid), 32'd0);
        chk("reset dramJ", 32'(dramJ), 32'd0);
        chk("reset ramWrData", 32'(ramWrData), 32'd0);
        chk("reset ldOverrun", 32'(ldOverrun), 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Lookup with a known word.
        ram[9'o250] = 24'hA507FF; mmem[9'o250] = 24'hA507FF;
        irOp = 9'o250; lookupReq = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!dramValid && n < 20);
        lookupReq = 1'b0;
        chk("lookup latency", 32'(n), 32'd3);
        chk("lookup dramA", 32'(dramA), 32'hA);
        chk("lookup dramB", 32'(dramB), 32'h5);
        chk("lookup dramJ", 32'(dramJ), 32'h7FF);
        @(negedge clk);

        // Single write.
        ldReq = 1'b1; ldAddr = 9'h1FF; ldData = 24'h123456;
        wr_cnt = 0; done_at = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            ldReq = 1'b0;
            if (ramWrEn) begin
                wr_cnt++;
                chk("write addr", 32'(ramWrAddr), 32'h1FF);
                chk("write data", 32'(ramWrData), 32'h123456);
            end
            if (ldDone && done_at == 0) done_at = i;
        end
        chk("write pulses", 32'(wr_cnt), 32'd1);
        chk("ldDone latency", 32'(done_at), 32'(WL));

        // Simultaneous write and lookup: write first.
        ram[9'h0AB] = 24'h3CF9AB; mmem[9'h0AB] = 24'h3CF9AB;
        ldReq = 1'b1; ldAddr = 9'h010; ldData = 24'h0BEEF0;
        lookupReq = 1'b1; irOp = 9'h0AB;
        done_at = 0; valid_at = 0; n = 0;
        do begin
            @(negedge clk); n++;
            ldReq = 1'b0;
            if (ldDone && done_at == 0) done_at = n;
            if (dramValid) valid_at = n;
        end while (!dramValid && n < 30);
        lookupReq = 1'b0;
        chk("simul valid time", 32'(valid_at), 32'(WL + 4));
        chk("simul done first", 32'(done_at), 32'(WL));
        chk("simul dramJ", 32'(dramJ), 32'h1AB);
        chk("simul dramA", 32'(dramA), 32'h3);
        @(negedge clk);

        // Write during a lookup is dropped.
        lookupReq = 1'b1; irOp = 9'o250;
        wr_cnt = 0; n = 0;
        do begin
            @(negedge clk); n++;
            ldReq = (n == 1);
            ldAddr = 9'o250; ldData = 24'h000000;
            if (ramWrEn) wr_cnt++;
        end while (!dramValid && n < 20);
        ldReq = 1'b0; lookupReq = 1'b0;
        chk("overrun set", 32'(ldOverrun), 32'd1);
        chk("overrun dramA", 32'(dramA), 32'hA);
        chk("overrun dramJ", 32'(dramJ), 32'h7FF);
        chk("overrun no write", 32'(wr_cnt), 32'd0);
        @(negedge clk);

        // Read-back mismatch sets ldErr; next accepted write clears it.
        ldReq = 1'b1; ldAddr = 9'h020; ldData = 24'hFFFFFF;
        done_at = 0; err_at_done = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            ldReq = 1'b0;
            if (ldDone && done_at == 0) begin done_at = i; err_at_done = ldErr; end
        end
        chk("ldErr at done", 32'(err_at_done), 32'(RB));
        ldReq = 1'b1; ldAddr = 9'h021; ldData = 24'h000111;
        @(negedge clk);
        ldReq = 1'b0;
        chk("ldErr cleared", 32'(ldErr), 32'd0);
        repeat (6) @(negedge clk);

        // Reset during WR.
        ldReq = 1'b1; ldAddr = 9'h033; ldData = 24'h5A5A5A;
        @(negedge clk);
        ldReq = 1'b0;
        chk("pre-reset wrEn", 32'(ramWrEn), 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("rst wrEn", 32'(ramWrEn), 32'd0);
        chk("rst ldBusy", 32'(ldBusy), 32'd0);
        chk("rst ramWrAddr", 32'(ramWrAddr), 32'd0);
        chk("rst ramWrData", 32'(ramWrData), 32'd0);
        chk("rst ldOverrun", 32'(ldOverrun), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        wr_cnt = 0; done_at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (ramWrEn) wr_cnt++;
            if (ldDone) done_at = i;
        end
        chk("post-reset wrEn", 32'(wr_cnt), 32'd0);
        chk("post-reset ldDone", 32'(done_at), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ldReq = ($urandom_range(0, 5) == 0);
            if (ldReq) begin
                ldAddr = 9'($urandom);
                ldData = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            end
            if (lookupReq && dramValid) lookupReq = 1'b0;
            else if (!lookupReq && $urandom_range(0, 3) == 0) begin
                lookupReq = 1'b1;
                irOp = 9'($urandom);
            end
        end
        ldReq = 1'b0; lookupReq = 1'b0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
